// File: rtl/alarm_clock_ctrl_multi.sv
// rtl/alarm_clock_ctrl_multi.sv - 24 h clock with NUM_ALARMS alarms, ring timeout and optional snooze
// Snooze logic is built only when ALARM_SNOOZE_EN is defined.
module alarm_clock_ctrl_multi #(
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [4:0]            btn,
    output logic [1:0]            disp_ht,
    output logic [3:0]            disp_hu,
    output logic [2:0]            disp_mt,
    output logic [3:0]            disp_mu,
    output logic [5:0]            seconds,
    output logic                  ring,
    output logic                  snooze_active,
    output logic [2:0]            alm_sel,
    output logic [NUM_ALARMS-1:0] alm_armed,
    output logic [4:0]            mode_led
);

    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_RING = 3'd1;
    localparam logic [2:0] S_TH   = 3'd2;
    localparam logic [2:0] S_TM   = 3'd3;
    localparam logic [2:0] S_AH   = 3'd4;
    localparam logic [2:0] S_AM   = 3'd5;

    localparam logic [2:0] SEL_LAST  = 3'(NUM_ALARMS - 1);
    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S);

    if (NUM_ALARMS < 1 || NUM_ALARMS > 8 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59 ||
        RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 255) begin : g_bad_params
        $error("alarm_clock_ctrl_multi: parameter out of range");
    end

    logic [2:0]            state_q, state_d;
    logic [4:0]            hour_q, hour_d;
    logic [5:0]            min_q, min_d;
    logic [5:0]            sec_q, sec_d;
    logic [4:0]            alm_h_q [NUM_ALARMS];
    logic [4:0]            alm_h_d [NUM_ALARMS];
    logic [5:0]            alm_m_q [NUM_ALARMS];
    logic [5:0]            alm_m_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed_q, armed_d;
    logic [2:0]            sel_q, sel_d;
    logic [7:0]            ring_cnt_q, ring_cnt_d;
    logic                  eval_q, eval_d;

    logic                  btn_ok, b_c, b_r, b_l, b_u, b_d;
    logic                  tick_adv, in_set;
    logic [NUM_ALARMS-1:0] sel_mask;
    logic [4:0]            cur_ah, disp_h;
    logic [5:0]            cur_am, disp_m;
    logic                  any_match, match_fire;
    logic [2:0]            match_idx;

    function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up);
        if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_min(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Only one-hot button values act; 0 and multi-hot patterns are dropped here.
    assign btn_ok   = (btn != 5'd0) && ((btn & (btn - 5'd1)) == 5'd0);
    assign b_c      = btn_ok & btn[0];
    assign b_r      = btn_ok & btn[1];
    assign b_l      = btn_ok & btn[2];
    assign b_u      = btn_ok & btn[3];
    assign b_d      = btn_ok & btn[4];
    assign tick_adv = tick_1hz && (state_q != S_TH) && (state_q != S_TM);

    always_comb begin
        sel_mask  = '0;
        cur_ah    = '0;
        cur_am    = '0;
        any_match = 1'b0;
        match_idx = '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            sel_mask[k] = (3'(k) == sel_q);
            if (3'(k) == sel_q) begin
                cur_ah = alm_h_q[k];
                cur_am = alm_m_q[k];
            end
        end
        // Scan downwards so the lowest matching index is the one that sticks.
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (armed_q[k] && alm_h_q[k] == hour_q && alm_m_q[k] == min_q) begin
                any_match = 1'b1;
                match_idx = 3'(k);
            end
        end
    end

    assign match_fire = eval_q && (state_q == S_RUN) && (sec_q == 6'd0) && any_match;

`ifdef ALARM_SNOOZE_EN
    localparam logic [5:0] SNZ_LOAD = 6'(SNOOZE_MIN);
    logic [5:0] snz_cnt_q, snz_cnt_d;
    logic       snz_act_q, snz_act_d;
    logic       snz_fire;
    assign snz_fire      = (state_q == S_RUN) && snz_act_q && (snz_cnt_q == 6'd0);
    assign snooze_active = snz_act_q;
`else
    assign snooze_active = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        alm_h_d    = alm_h_q;
        alm_m_d    = alm_m_q;
        armed_d    = armed_q;
        sel_d      = sel_q;
        ring_cnt_d = ring_cnt_q;
        eval_d     = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
        snz_act_d  = snz_act_q;
`endif
        if (tick_adv) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        case (state_q)
            S_RUN: begin
                eval_d = tick_1hz;
`ifdef ALARM_SNOOZE_EN
                if (tick_1hz && sec_q == 6'd59 && snz_act_q && snz_cnt_q != 6'd0)
                    snz_cnt_d = snz_cnt_q - 6'd1;
`endif
                if (match_fire) begin
                    state_d    = S_RING;
                    sel_d      = match_idx;
                    ring_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_EN
                    snz_act_d  = 1'b0;
                end else if (snz_fire) begin
                    state_d    = S_RING;
                    ring_cnt_d = 8'd0;
                    snz_act_d  = 1'b0;
`endif
                end else if (b_c) begin
                    state_d = S_TH;
                end else if (b_u) begin
                    sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
                end else if (b_d) begin
                    armed_d = armed_q ^ sel_mask;
                end
            end
            S_RING: begin
                if (btn_ok) begin
                    state_d = S_RUN;
`ifdef ALARM_SNOOZE_EN
                    if (!b_c) begin
                        snz_act_d = 1'b1;
                        snz_cnt_d = SNZ_LOAD;
                    end
`endif
                end else if (tick_1hz) begin
                    if (ring_cnt_q + 8'd1 == RING_LAST) state_d = S_RUN;
                    else ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
            S_TH, S_TM, S_AH, S_AM: begin
                if (b_c) begin
                    state_d = S_RUN;
                end else if (b_u || b_d) begin
                    case (state_q)
                        S_TH: hour_d = step_hour(hour_q, b_u);
                        S_TM: begin
                            min_d = step_min(min_q, b_u);
                            sec_d = 6'd0;
                        end
                        S_AH: for (int k = 0; k < NUM_ALARMS; k++)
                                  if (sel_mask[k]) alm_h_d[k] = step_hour(alm_h_q[k], b_u);
                        default: for (int k = 0; k < NUM_ALARMS; k++)
                                  if (sel_mask[k]) alm_m_d[k] = step_min(alm_m_q[k], b_u);
                    endcase
                end else if (b_r) begin
                    case (state_q)
                        S_TH: state_d = S_TM;
                        S_TM: state_d = S_AH;
                        S_AH: state_d = S_AM;
                        default: begin
                            if (sel_q == SEL_LAST) begin
                                sel_d   = 3'd0;
                                state_d = S_TH;
                            end else begin
                                sel_d   = sel_q + 3'd1;
                                state_d = S_AH;
                            end
                        end
                    endcase
                end else if (b_l) begin
                    case (state_q)
                        S_TH: begin
                            sel_d   = SEL_LAST;
                            state_d = S_AM;
                        end
                        S_TM: state_d = S_TH;
                        S_AH: begin
                            if (sel_q == 3'd0) begin
                                state_d = S_TM;
                            end else begin
                                sel_d   = sel_q - 3'd1;
                                state_d = S_AM;
                            end
                        end
                        default: state_d = S_AH;
                    endcase
                end
            end
            default: state_d = S_RUN;
        endcase

        in_set = (state_d == S_TH) || (state_d == S_TM) || (state_d == S_AH) || (state_d == S_AM);
`ifdef ALARM_SNOOZE_EN
        if (in_set) snz_act_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            armed_q    <= '0;
            sel_q      <= '0;
            ring_cnt_q <= '0;
            eval_q     <= 1'b0;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                alm_h_q[k] <= '0;
                alm_m_q[k] <= '0;
            end
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
            snz_act_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            armed_q    <= armed_d;
            sel_q      <= sel_d;
            ring_cnt_q <= ring_cnt_d;
            eval_q     <= eval_d;
            alm_h_q    <= alm_h_d;
            alm_m_q    <= alm_m_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
            snz_act_q  <= snz_act_d;
`endif
        end
    end

    always_comb begin
        disp_h = ((state_q == S_AH) || (state_q == S_AM)) ? cur_ah : hour_q;
        disp_m = ((state_q == S_AH) || (state_q == S_AM)) ? cur_am : min_q;
        if (disp_h >= 5'd20)      disp_ht = 2'd2;
        else if (disp_h >= 5'd10) disp_ht = 2'd1;
        else                      disp_ht = 2'd0;
        disp_hu = 4'(disp_h - {3'd0, disp_ht} * 5'd10);
        if (disp_m >= 6'd50)      disp_mt = 3'd5;
        else if (disp_m >= 6'd40) disp_mt = 3'd4;
        else if (disp_m >= 6'd30) disp_mt = 3'd3;
        else if (disp_m >= 6'd20) disp_mt = 3'd2;
        else if (disp_m >= 6'd10) disp_mt = 3'd1;
        else                      disp_mt = 3'd0;
        disp_mu = 4'(disp_m - {3'd0, disp_mt} * 6'd10);
        case (state_q)
            S_RING:  mode_led = {4'b0000, sec_q[0]};
            S_TH:    mode_led = 5'b10001;
            S_TM:    mode_led = 5'b01001;
            S_AH:    mode_led = 5'b00101;
            S_AM:    mode_led = 5'b00011;
            default: mode_led = 5'b00000;
        endcase
    end

    assign seconds   = sec_q;
    assign ring      = (state_q == S_RING);
    assign alm_sel   = sel_q;
    assign alm_armed = armed_q;

endmodule

// File: tb/tb_alarm_clock_ctrl_multi.sv
// tb/tb_alarm_clock_ctrl_multi.sv - table-driven and sequence checks for alarm_clock_ctrl_multi
module tb_alarm_clock_ctrl_multi;
    localparam int NA = 4;
    localparam logic [4:0] BC = 5'b00001, BR = 5'b00010, BL = 5'b00100, BU = 5'b01000, BD = 5'b10000;
    localparam logic [4:0] M_RUN = 5'b00000, M_TH = 5'b10001, M_TM = 5'b01001, M_AH = 5'b00101, M_AM = 5'b00011;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick_1hz = 1'b0;
    logic [4:0]    btn = 5'd0;
    logic [1:0]    disp_ht;
    logic [3:0]    disp_hu;
    logic [2:0]    disp_mt;
    logic [3:0]    disp_mu;
    logic [5:0]    seconds;
    logic          ring;
    logic          snooze_active;
    logic [2:0]    alm_sel;
    logic [NA-1:0] alm_armed;
    logic [4:0]    mode_led;

    alarm_clock_ctrl_multi #(.NUM_ALARMS(NA), .SNOOZE_MIN(5), .RING_TIMEOUT_S(60)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn(btn),
        .disp_ht(disp_ht), .disp_hu(disp_hu), .disp_mt(disp_mt), .disp_mu(disp_mu),
        .seconds(seconds), .ring(ring), .snooze_active(snooze_active),
        .alm_sel(alm_sel), .alm_armed(alm_armed), .mode_led(mode_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] b;
        logic       t;
        logic [4:0] mode;
        int         sel;
        int         h;
        int         m;
        int         s;
        logic [3:0] arm;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic ring_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] b, input logic t, input logic [4:0] mode, input int sel,
                       input int h, input int m, input int s, input logic [3:0] arm);
        vec_t v;
        v.b = b; v.t = t; v.mode = mode; v.sel = sel; v.h = h; v.m = m; v.s = s; v.arm = arm;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [4:0] b, input logic t);
        @(negedge clk);
        btn = b;
        tick_1hz = t;
        @(posedge clk);
        #1;
        btn = 5'd0;
        tick_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(5'd0, 1'b1);
            if (ring) ring_seen = 1'b1;
        end
    endtask

    task automatic chk_disp(input string name, input int h, input int m);
        chk({name, " ht"}, int'(disp_ht), h / 10);
        chk({name, " hu"}, int'(disp_hu), h % 10);
        chk({name, " mt"}, int'(disp_mt), m / 10);
        chk({name, " mu"}, int'(disp_mu), m % 10);
    endtask

    // Move the clock minutes from the current value down by two via SET_TM and return to RUN.
    task automatic rewind_two_minutes();
        step(BC, 1'b0);
        step(BR, 1'b0);
        step(BD, 1'b0);
        step(BD, 1'b0);
        step(BC, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Starting point: RUN at 00:01:30, alm_sel 0, nothing armed.
        add(BC,    1'b0, M_TH, 0, 0, 1, 30, 4'b0000);
        add(5'd0,  1'b1, M_TH, 0, 0, 1, 30, 4'b0000);
        add(BD,    1'b0, M_TH, 0, 23, 1, 30, 4'b0000);
        add(BU,    1'b0, M_TH, 0, 0, 1, 30, 4'b0000);
        add(BR,    1'b0, M_TM, 0, 0, 1, 30, 4'b0000);
        add(5'd0,  1'b1, M_TM, 0, 0, 1, 30, 4'b0000);
        add(BD,    1'b0, M_TM, 0, 0, 0, 0, 4'b0000);
        add(BD,    1'b0, M_TM, 0, 0, 59, 0, 4'b0000);
        add(5'd0,  1'b1, M_TM, 0, 0, 59, 0, 4'b0000);
        add(BU,    1'b0, M_TM, 0, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_AH, 0, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_AM, 0, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_AH, 1, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_AM, 1, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_AH, 2, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_AH, 2, 1, 0, 0, 4'b0000);
        add(BD,    1'b0, M_AH, 2, 0, 0, 0, 4'b0000);
        add(BD,    1'b0, M_AH, 2, 23, 0, 0, 4'b0000);
        add(BU,    1'b0, M_AH, 2, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_AM, 2, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_AM, 2, 0, 1, 0, 4'b0000);
        add(BU,    1'b0, M_AM, 2, 0, 2, 0, 4'b0000);
        add(BU,    1'b0, M_AM, 2, 0, 3, 0, 4'b0000);
        add(BD,    1'b0, M_AM, 2, 0, 2, 0, 4'b0000);
        add(BU,    1'b0, M_AM, 2, 0, 3, 0, 4'b0000);
        add(BL,    1'b0, M_AH, 2, 0, 3, 0, 4'b0000);
        add(BR,    1'b0, M_AM, 2, 0, 3, 0, 4'b0000);
        add(BR,    1'b0, M_AH, 3, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_AM, 3, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_TH, 0, 0, 0, 0, 4'b0000);
        add(BL,    1'b0, M_AM, 3, 0, 0, 0, 4'b0000);
        add(BR,    1'b0, M_TH, 0, 0, 0, 0, 4'b0000);
        add(5'd0,  1'b1, M_TH, 0, 0, 0, 0, 4'b0000);
        add(BC,    1'b0, M_RUN, 0, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_RUN, 1, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_RUN, 2, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_RUN, 3, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_RUN, 0, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_RUN, 1, 0, 0, 0, 4'b0000);
        add(BU,    1'b0, M_RUN, 2, 0, 0, 0, 4'b0000);
        add(BD,    1'b0, M_RUN, 2, 0, 0, 0, 4'b0100);
        add(5'b00011, 1'b0, M_RUN, 2, 0, 0, 0, 4'b0100);
        add(BR,    1'b0, M_RUN, 2, 0, 0, 0, 4'b0100);
        add(BL,    1'b0, M_RUN, 2, 0, 0, 0, 4'b0100);
        add(BD,    1'b0, M_RUN, 2, 0, 0, 0, 4'b0000);
        add(BD,    1'b0, M_RUN, 2, 0, 0, 0, 4'b0100);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk_disp("reset", 0, 0);
        chk("reset seconds", int'(seconds), 0);
        chk("reset ring", int'(ring), 0);
        chk("reset snooze", int'(snooze_active), 0);
        chk("reset sel", int'(alm_sel), 0);
        chk("reset armed", int'(alm_armed), 0);
        chk("reset mode", int'(mode_led), 0);
        @(negedge clk);
        rst = 1'b1;

        ring_seen = 1'b0;
        ticks(90);
        chk_disp("90 ticks", 0, 1);
        chk("90 ticks seconds", int'(seconds), 30);
        chk("90 ticks no ring", int'(ring_seen), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].b, tbl[i].t);
            chk_disp($sformatf("row%0d", i), tbl[i].h, tbl[i].m);
            chk($sformatf("row%0d seconds", i), int'(seconds), tbl[i].s);
            chk($sformatf("row%0d mode", i), int'(mode_led), int'(tbl[i].mode));
            chk($sformatf("row%0d sel", i), int'(alm_sel), tbl[i].sel);
            chk($sformatf("row%0d armed", i), int'(alm_armed), int'(tbl[i].arm));
        end

        // Alarm 2 at 00:03 fires one clock after the tick that produces 00:03:00.
        ring_seen = 1'b0;
        ticks(180);
        chk("fire pre ring", int'(ring_seen), 0);
        chk_disp("fire time", 0, 3);
        step(5'd0, 1'b0);
        chk("fire ring", int'(ring), 1);
        chk("fire sel", int'(alm_sel), 2);
        chk("fire mode even", int'(mode_led), 0);
        ticks(1);
        chk("ring mode odd", int'(mode_led), 1);
        ticks(1);
        chk("ring mode even", int'(mode_led), 0);

        // Timeout after 60 unattended ticks.
        ticks(57);
        chk("timeout tick59 ring", int'(ring), 1);
        ticks(1);
        chk("timeout ring", int'(ring), 0);
        chk("timeout mode", int'(mode_led), 0);
        chk_disp("timeout time", 0, 4);
        chk("timeout seconds", int'(seconds), 0);

        // C on the same cycle as the 60th ring tick dismisses once.
        rewind_two_minutes();
        chk_disp("rewind", 0, 2);
        ticks(60);
        step(5'd0, 1'b0);
        chk("refire ring", int'(ring), 1);
        ticks(59);
        chk("c+timeout pre ring", int'(ring), 1);
        step(BC, 1'b1);
        chk("c+timeout ring", int'(ring), 0);
        chk("c+timeout mode", int'(mode_led), 0);
        step(5'd0, 1'b0);
        chk("c+timeout stays run", int'(mode_led), 0);
        chk("c+timeout armed", int'(alm_armed), 4);

        // Non-C button while ringing.
        rewind_two_minutes();
        ticks(60);
        step(5'd0, 1'b0);
        chk("third ring", int'(ring), 1);
        step(BU, 1'b0);
        chk("u in ring ring", int'(ring), 0);
        chk("u in ring sel", int'(alm_sel), 2);
`ifdef ALARM_SNOOZE_EN
        chk("snooze active", int'(snooze_active), 1);
        ring_seen = 1'b0;
        ticks(300);
        chk("snooze pre ring", int'(ring_seen), 0);
        chk_disp("snooze time", 0, 8);
        step(5'd0, 1'b0);
        chk("snooze ring", int'(ring), 1);
        chk("snooze cleared", int'(snooze_active), 0);
        chk("snooze sel", int'(alm_sel), 2);
        step(BU, 1'b0);
        chk("snooze again", int'(snooze_active), 1);
        step(BC, 1'b0);
        chk("set cancels snooze", int'(snooze_active), 0);
        chk("set mode", int'(mode_led), int'(M_TH));
        step(BC, 1'b0);
`else
        chk("no snooze", int'(snooze_active), 0);
        chk("u dismiss mode", int'(mode_led), 0);
        step(5'd0, 1'b0);
        chk("u dismiss stays", int'(ring), 0);
`endif

        // Asynchronous reset mid-operation.
        #3;
        rst = 1'b0;
        #1;
        chk_disp("async reset", 0, 0);
        chk("async reset armed", int'(alm_armed), 0);
        chk("async reset sel", int'(alm_sel), 0);
        chk("async reset ring", int'(ring), 0);
        chk("async reset snooze", int'(snooze_active), 0);
        @(negedge clk);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
